uart_rx_sampler: RTL and testbench

Timing and data-recovery stage of the UART receiver, sitting directly upstream of the RX control FSM.
- Generates the per-bit oversampling edge counter and the frame bit counter that the FSM decodes.
- Majority-votes three mid-bit samples of the serial line into a single recovered bit, consumed by the deserializer and the start/parity/stop checkers.
- Enabled and gated by the FSM's registered enable and dat_samp_en outputs.

---
 rtl/uart_rx_sampler.sv | 127 ++++++++++++
 tb/tb_uart_rx_sampler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// UART RX timing/data-recovery stage: oversampling edge counter, frame bit counter, 3-sample majority vote.
// Optional SAMPLER_SYNC_EN: adds a 2-flop synchronizer (reset value 1) on RX_IN ahead of all sampling.
module uart_rx_sampler #(
  parameter int EDGE_W = 6,
  parameter int BIT_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic [5:0]        Prescale,
  input  logic              enable,
  input  logic              dat_samp_en,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              sampled_bit,
  output logic              samp_valid,
  output logic              presc_err
);

  logic [5:0]        r_presc;
  logic              r_presc_err;
  logic              r_enable_d;
  logic [EDGE_W-1:0] r_edge_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_s0, r_s1, r_s2;
  logic              r_sampled_bit;
  logic              r_samp_valid;

  logic              w_line;
  logic              w_presc_ok;
  logic [5:0]        w_half;
  logic [EDGE_W-1:0] w_last;
  logic [EDGE_W-1:0] w_h_m1;
  logic [EDGE_W-1:0] w_h;
  logic [EDGE_W-1:0] w_h_p1;
  logic [EDGE_W-1:0] w_h_p2;
  logic              w_vote;

`ifdef SAMPLER_SYNC_EN
  logic r_sync1, r_sync2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2;
`else
  assign w_line = RX_IN;
`endif

  assign w_presc_ok = (Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32);
  assign w_half     = r_presc >> 1;
  assign w_last     = EDGE_W'(r_presc - 6'd1);
  assign w_h_m1     = EDGE_W'(w_half - 6'd1);
  assign w_h        = EDGE_W'(w_half);
  assign w_h_p1     = EDGE_W'(w_half + 6'd1);
  assign w_h_p2     = EDGE_W'(w_half + 6'd2);
  assign w_vote     = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);

  // Prescale is only sampled while idle, so a frame always runs at the ratio it started with.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_presc     <= 6'd8;
      r_presc_err <= 1'b0;
      r_enable_d  <= 1'b0;
      r_edge_cnt  <= '0;
      r_bit_cnt   <= '0;
    end else begin
      r_enable_d <= enable;
      if (!enable) begin
        r_presc     <= w_presc_ok ? Prescale : 6'd8;
        r_presc_err <= ~w_presc_ok;
        r_edge_cnt  <= '0;
        r_bit_cnt   <= '0;
      end else if (!r_enable_d) begin
        r_edge_cnt <= EDGE_W'(1);
        r_bit_cnt  <= BIT_W'(1);
      end else if (r_edge_cnt == w_last) begin
        r_edge_cnt <= '0;
        if (r_bit_cnt != {BIT_W{1'b1}}) begin
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
      end else begin
        r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
      end
    end
  end

  // Sample regs return to idle-high whenever the FSM is disabled so an aborted frame leaves nothing behind.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s0          <= 1'b1;
      r_s1          <= 1'b1;
      r_s2          <= 1'b1;
      r_sampled_bit <= 1'b1;
      r_samp_valid  <= 1'b0;
    end else begin
      r_samp_valid <= 1'b0;
      if (!enable) begin
        r_s0 <= 1'b1;
        r_s1 <= 1'b1;
        r_s2 <= 1'b1;
      end else if (dat_samp_en) begin
        if (r_edge_cnt == w_h_m1) r_s0 <= w_line;
        if (r_edge_cnt == w_h)    r_s1 <= w_line;
        if (r_edge_cnt == w_h_p1) r_s2 <= w_line;
        if (r_edge_cnt == w_h_p2) begin
          r_sampled_bit <= w_vote;
          r_samp_valid  <= 1'b1;
        end
      end
    end
  end

  assign edge_cnt    = r_edge_cnt;
  assign bit_cnt     = r_bit_cnt;
  assign sampled_bit = r_sampled_bit;
  assign samp_valid  = r_samp_valid;
  assign presc_err   = r_presc_err;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: frame-level reference model feeds an expectation queue, a monitor checks each samp_valid.
// Honours SAMPLER_SYNC_EN by shifting the model's view of the line by two cycles.
module tb_uart_rx_sampler;

  localparam int EDGE_W  = 6;
  localparam int BIT_W   = 4;
  localparam int BIT_MAX = (1 << BIT_W) - 1;
`ifdef SAMPLER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              RX_IN = 1'b1;
  logic [5:0]        Prescale = 6'd8;
  logic              enable = 1'b0;
  logic              dat_samp_en = 1'b0;
  logic [EDGE_W-1:0] edge_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              sampled_bit;
  logic              samp_valid;
  logic              presc_err;

  typedef struct {
    int bitVal;
    int edgeAt;
    int bitAt;
  } exp_t;

  exp_t expQ[$];
  logic lineArr[0:511];
  logic dseBit[0:31];
  int   checks   = 0;
  int   failures = 0;

  uart_rx_sampler #(.EDGE_W(EDGE_W), .BIT_W(BIT_W)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .enable(enable), .dat_samp_en(dat_samp_en),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sampled_bit(sampled_bit),
    .samp_valid(samp_valid), .presc_err(presc_err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int effPresc(input int p);
    return (p == 8 || p == 16 || p == 32) ? p : 8;
  endfunction

  function automatic int satBit(input int b);
    return (b > BIT_MAX) ? BIT_MAX : b;
  endfunction

  function automatic int lineSeen(input int c);
    return (c - LAT < 0) ? 1 : int'(lineArr[c - LAT]);
  endfunction

  function automatic logic [5:0] pickPresc();
    case ($urandom_range(0, 5))
      0: return 6'd8;
      1: return 6'd16;
      2: return 6'd32;
      3: return 6'd12;
      4: return 6'd0;
      default: return 6'd40;
    endcase
  endfunction

  // Bit b spans frame cycles (b-1)*P .. b*P-1; its three mid-bit samples vote, result seen at H+3.
  task automatic pushExpectations(input int presc, input int ncyc);
    int p;
    int h;
    int base;
    int votes;
    p = effPresc(presc);
    h = p / 2;
    for (int b = 1; (b - 1) * p + h + 2 < ncyc; b++) begin
      if (dseBit[b]) begin
        base  = (b - 1) * p;
        votes = lineSeen(base + h - 1) + lineSeen(base + h) + lineSeen(base + h + 1);
        expQ.push_back('{(votes >= 2) ? 1 : 0, h + 3, satBit(b)});
      end
    end
  endtask

  task automatic fillLine(input int n, input logic v);
    for (int c = 0; c < n; c++) lineArr[c] = v;
  endtask

  task automatic fillDse(input logic v);
    for (int b = 0; b < 32; b++) dseBit[b] = v;
  endtask

  task automatic genRandom(input int p, input int ncyc, input bit randDse);
    logic v;
    v = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (c % p == 0) v = logic'($urandom_range(0, 1));
      lineArr[c] = ($urandom_range(0, 3) == 0) ? ~v : v;
    end
    for (int b = 0; b < 32; b++) dseBit[b] = randDse ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic applyStimulus(input int presc, input int ncyc, input bit resetAbort);
    int p;
    int errExp;
    p      = effPresc(presc);
    errExp = (p == presc) ? 0 : 1;
    pushExpectations(presc, ncyc);
    enable      = 1'b0;
    dat_samp_en = 1'b0;
    RX_IN       = 1'b1;
    Prescale    = 6'(presc);
    repeat (3) begin
      @(posedge CLK); #1;
      checkOutput("idle_edge_cnt", int'(edge_cnt), 0);
      checkOutput("idle_bit_cnt", int'(bit_cnt), 0);
      checkOutput("idle_presc_err", int'(presc_err), errExp);
    end
    for (int c = 0; c <= ncyc; c++) begin
      checkOutput("edge_cnt", int'(edge_cnt), c % p);
      checkOutput("bit_cnt", int'(bit_cnt), (c == 0) ? 0 : satBit(c / p + 1));
      checkOutput("frame_presc_err", int'(presc_err), errExp);
      if (c == ncyc) break;
      enable      = 1'b1;
      RX_IN       = lineArr[c];
      dat_samp_en = dseBit[c / p + 1];
      if (c == 0 || c == p + 2) Prescale = pickPresc();
      @(posedge CLK); #1;
    end
    if (resetAbort) begin
      #2 RST = 1'b0;
      #1;
      checkOutput("rst_edge_cnt", int'(edge_cnt), 0);
      checkOutput("rst_bit_cnt", int'(bit_cnt), 0);
      checkOutput("rst_sampled_bit", int'(sampled_bit), 1);
      checkOutput("rst_samp_valid", int'(samp_valid), 0);
      checkOutput("rst_presc_err", int'(presc_err), 0);
      enable      = 1'b0;
      dat_samp_en = 1'b0;
      RX_IN       = 1'b1;
      @(posedge CLK); #3 RST = 1'b1;
    end else begin
      enable      = 1'b0;
      dat_samp_en = 1'b0;
      RX_IN       = 1'b1;
      @(posedge CLK); #1;
      checkOutput("abort_edge_cnt", int'(edge_cnt), 0);
      checkOutput("abort_bit_cnt", int'(bit_cnt), 0);
    end
  endtask

  // Monitor: every samp_valid pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST === 1'b1 && samp_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("valid_without_expectation", int'(samp_valid), 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sampled_bit", int'(sampled_bit), e.bitVal);
          checkOutput("valid_edge_cnt", int'(edge_cnt), e.edgeAt);
          checkOutput("valid_bit_cnt", int'(bit_cnt), e.bitAt);
        end
      end
    end
  end

  initial begin
    int p;
    int presc;
    int ncyc;
    RST = 1'b1;
    #1 RST = 1'b0;
    #1;
    checkOutput("reset_edge_cnt", int'(edge_cnt), 0);
    checkOutput("reset_bit_cnt", int'(bit_cnt), 0);
    checkOutput("reset_sampled_bit", int'(sampled_bit), 1);
    checkOutput("reset_samp_valid", int'(samp_valid), 0);
    checkOutput("reset_presc_err", int'(presc_err), 0);
    #19 RST = 1'b1;

    fillDse(1'b1);
    fillLine(16, 1'b0);
    applyStimulus(8, 16, 1'b0);

    fillLine(16, 1'b1);
    lineArr[4]  = 1'b0;
    lineArr[11] = 1'b0;
    lineArr[13] = 1'b0;
    applyStimulus(8, 16, 1'b0);

    fillLine(32, 1'b1);
    lineArr[7] = 1'b0;
    lineArr[8] = 1'b0;
    lineArr[9] = 1'b0;
    applyStimulus(16, 32, 1'b0);

    genRandom(8, 24, 1'b0);
    applyStimulus(12, 24, 1'b0);

    genRandom(8, 35, 1'b0);
    applyStimulus(8, 35, 1'b0);

    genRandom(8, 32, 1'b0);
    dseBit[2] = 1'b0;
    applyStimulus(8, 32, 1'b0);

    fillDse(1'b1);
    fillLine(35, 1'b0);
    applyStimulus(8, 35, 1'b1);

    genRandom(8, 136, 1'b0);
    applyStimulus(8, 136, 1'b0);

    for (int i = 0; i < 20; i++) begin
      presc = int'(pickPresc());
      p     = effPresc(presc);
      ncyc  = $urandom_range(p, 12 * p);
      genRandom(p, ncyc, 1'b1);
      applyStimulus(presc, ncyc, 1'b0);
    end

    repeat (5) @(posedge CLK);
    #1;
    checkOutput("scoreboard_drain", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
